alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Two-requester round-robin arbiter and sequencer for the shared 32-bit integer ALU. It accepts operation requests (ALU control code plus two operands) from two clients over valid/ready handshakes and drives the ALU from registered operands. It captures result and flags into a response register and returns them to the granted client over a second valid/ready handshake. It sits between the ALU and its clients, for example the execute stage and a multi-cycle address/CSR helper, so the ALU has a single driver.

## Interface
- `WIDTH`, 32, datapath width of operands and result. Only 32 is supported.
- `clk` input 1: the single clock. All state updates on the rising edge.
- `rst_n` input 1: synchronous, active-low reset, sampled on the rising edge of `clk`.
- `req0_valid`, `req1_valid` input 1 each: client n presents a request.
- `req0_ready`, `req1_ready` output 1 each: client n's request is accepted this cycle.
- `req0_op`, `req1_op` input 3 each: ALU control code (000 add, 001 shl, 010 sub, 100 xor, 101 sra, 110 or, 111 and).
- `req0_a`, `req0_b`, `req1_a`, `req1_b` input WIDTH each: operands.
- `rsp0_valid`, `rsp1_valid` output 1 each: response pending for client n.
- `rsp0_ready`, `rsp1_ready` input 1 each: client n consumes the response.
- `rsp_result` output WIDTH: registered ALU result, shared by both clients.
- `rsp_zero`, `rsp_sign` output 1 each: registered zero and sign flags, shared.
- `alu_ctrl` output 3, `alu_a` output WIDTH, `alu_b` output WIDTH: ALU drive, taken straight from the operand registers.
- `alu_result` input WIDTH, `alu_zero` input 1, `alu_sign` input 1: combinational ALU outputs.
- `busy` output 1: high in every state except IDLE.
- `grant_id` output 1: index of the client currently being served.

## Operation
- FSM states: IDLE, EXEC, RESP.
- **IDLE:**
  - Winner selection: if only one `reqN_valid` is high, that client wins. If both are high, the client indicated by the priority pointer `prio` wins.
  - The winner's `reqN_ready` is driven high combinationally in the same cycle. The loser's ready stays low.
  - On acceptance: latch op, a and b into the operand registers, latch `grant_id`, and go to EXEC.
  - If no request is valid, stay in IDLE.
- **EXEC:**
  - `alu_*` outputs carry the latched operands.
  - At the clock edge, capture `alu_result`, `alu_zero` and `alu_sign` into `rsp_result`, `rsp_zero` and `rsp_sign`, then go to RESP.
- **RESP:**
  - `rsp<grant_id>_valid` is high. The other `rsp_valid` is low.
  - Response data is held stable until `rsp<grant_id>_ready` is high.
  - On that handshake: set `prio` to the non-served client, clear `rsp_valid`, and return to IDLE.
  - `rspN_ready` is ignored when `rspN_valid` is low.
- Both `req_ready` outputs are low in EXEC and RESP. A client must hold its request stable while valid is high and ready is low.
- Operands are registered at acceptance, so the client may change them in the cycle after acceptance.
- Undefined op 011 is passed through unchanged. The response is whatever the ALU returns (result 0, zero=1, sign=0).
- `prio` changes only on response completion. It does not change on acceptance.

## Timing
- Reset values (while `rst_n`=0 at an edge):
  - state IDLE, `prio`=0, `grant_id`=0, `busy`=0.
  - Both `rsp_valid`=0; `rsp_result`=0, `rsp_zero`=0, `rsp_sign`=0.
  - Operand registers 0, so `alu_ctrl`=000, `alu_a`=0, `alu_b`=0.
  - Both `req_ready`=0 while `rst_n` is low.
- Latency: accept at edge T, capture at edge T+1, `rsp_valid` visible in the cycle after T+1.
  - This is 2 cycles from accept to response-valid.
  - Minimum issue interval is 3 cycles, assuming `rsp_ready` is already high.
- Backpressure: RESP holds indefinitely while `rsp_ready` is low. No new request is accepted during RESP.
- Reset during EXEC or RESP aborts the operation. No response is delivered and all reset values apply at the next edge.
- `reqN_valid` asserted in the same cycle as the RESP→IDLE handshake is not accepted until the next cycle, which is IDLE.
- No combinational path from `alu_*` inputs to any output. Ready outputs depend only on state, the `req_valid` inputs and `prio`.

## Test plan
- **Reset:** hold `rst_n`=0 for 2 cycles with both requests valid → both readies 0, both `rsp_valid` 0, `busy`=0, `alu_a`=`alu_b`=0.
- **Single add:** req0 op=000, a=5, b=7 → `req0_ready` high in the accept cycle, `rsp0_valid` 2 cycles later, `rsp_result`=12, zero=0, sign=0.
- **Round-robin contention:** both clients valid continuously, req0 sub 3−3, req1 sra 0x80000000>>>4.
  - First grant goes to client 0: result 0, zero=1.
  - Next grant goes to client 1: result 0xF8000000, sign=1.
  - Grants then alternate 0,1,0.
- **Backpressure:** hold `rsp1_ready`=0 for 5 cycles → `rsp1_valid` and `rsp_result` stay stable, `busy` stays 1, `req0_ready` stays 0 throughout, and completion occurs on the cycle `rsp1_ready` rises.
- **Mid-operation reset:** assert `rst_n`=0 during EXEC, then deassert → no `rsp_valid` pulse, `prio`=0, and the next contended grant goes to client 0.
- **Undefined op:** op=011, a=9, b=9 → `rsp_result`=0, zero=1, sign=0, handshake completes normally.

Source files
------------

// File: rtl/alu_arbiter.sv
// Two-client round-robin front end for the shared 32-bit ALU.
// Requests are accepted and their operands registered, the ALU result is captured, and the response is returned to the client that was granted.
module alu_arbiter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [2:0]       req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [2:0]       req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_zero,
    output logic             rsp_sign,
    output logic [2:0]       alu_ctrl,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero,
    input  logic             alu_sign,
    output logic             busy,
    output logic             grant_id
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state;
    logic             prio;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             win0;
    logic             win1;
    logic             rsp_done;

    // A lone requester always wins; under contention the priority pointer decides.
    always_comb begin
        win0     = req0_valid && (!req1_valid || !prio);
        win1     = req1_valid && (!req0_valid || prio);
        rsp_done = grant_id ? rsp1_ready : rsp0_ready;
    end

    assign req0_ready = rst_n && (state == IDLE) && win0;
    assign req1_ready = rst_n && (state == IDLE) && win1;

    assign alu_ctrl = op_q;
    assign alu_a    = a_q;
    assign alu_b    = b_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            prio       <= 1'b0;
            grant_id   <= 1'b0;
            busy       <= 1'b0;
            op_q       <= 3'd0;
            a_q        <= '0;
            b_q        <= '0;
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            rsp_result <= '0;
            rsp_zero   <= 1'b0;
            rsp_sign   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (win0 || win1) begin
                        op_q     <= win1 ? req1_op : req0_op;
                        a_q      <= win1 ? req1_a  : req0_a;
                        b_q      <= win1 ? req1_b  : req0_b;
                        grant_id <= win1;
                        busy     <= 1'b1;
                        state    <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_result <= alu_result;
                    rsp_zero   <= alu_zero;
                    rsp_sign   <= alu_sign;
                    rsp0_valid <= !grant_id;
                    rsp1_valid <= grant_id;
                    state      <= RESP;
                end
                RESP: begin
                    // Response is held until the granted client takes it.
                    if (rsp_done) begin
                        prio       <= !grant_id;
                        rsp0_valid <= 1'b0;
                        rsp1_valid <= 1'b0;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter with a behavioural ALU attached.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [2:0]  req0_op, req1_op;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
    logic [31:0] rsp_result;
    logic        rsp_zero, rsp_sign;
    logic [2:0]  alu_ctrl;
    logic [31:0] alu_a, alu_b, alu_result;
    logic        alu_zero, alu_sign;
    logic        busy, grant_id;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_sign(rsp_sign),
        .alu_ctrl(alu_ctrl), .alu_a(alu_a), .alu_b(alu_b),
        .alu_result(alu_result), .alu_zero(alu_zero), .alu_sign(alu_sign),
        .busy(busy), .grant_id(grant_id)
    );

    // Shared ALU, decoded from the arbiter's drive.
    always_comb begin
        case (alu_ctrl)
            3'b000:  alu_result = alu_a + alu_b;
            3'b001:  alu_result = alu_a << alu_b[4:0];
            3'b010:  alu_result = alu_a - alu_b;
            3'b100:  alu_result = alu_a ^ alu_b;
            3'b101:  alu_result = 32'($signed(alu_a) >>> alu_b[4:0]);
            3'b110:  alu_result = alu_a | alu_b;
            3'b111:  alu_result = alu_a & alu_b;
            default: alu_result = 32'd0;
        endcase
        alu_zero = (alu_result == 32'd0);
        alu_sign = alu_result[31];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Runs one grant from IDLE at a falling edge to the IDLE falling edge after the handshake.
    // Requests must already be driven; rsp ready of the winner must be high.
    task automatic serve(input string tag, input logic id, input logic [31:0] er,
                         input logic ez, input logic es);
        #1;
        chk({tag, " req0_ready"}, 32'(req0_ready), 32'(!id));
        chk({tag, " req1_ready"}, 32'(req1_ready), 32'(id));
        @(negedge clk);
        chk({tag, " exec busy"}, 32'(busy), 32'd1);
        chk({tag, " exec rsp_valid"}, 32'({rsp1_valid, rsp0_valid}), 32'd0);
        chk({tag, " exec readies"}, 32'({req1_ready, req0_ready}), 32'd0);
        @(negedge clk);
        chk({tag, " rsp_valid"}, 32'({rsp1_valid, rsp0_valid}), id ? 32'd2 : 32'd1);
        chk({tag, " grant_id"}, 32'(grant_id), 32'(id));
        chk({tag, " result"}, rsp_result, er);
        chk({tag, " zero"}, 32'(rsp_zero), 32'(ez));
        chk({tag, " sign"}, 32'(rsp_sign), 32'(es));
        @(negedge clk);
        chk({tag, " done busy"}, 32'(busy), 32'd0);
        chk({tag, " done rsp_valid"}, 32'({rsp1_valid, rsp0_valid}), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        req0_valid = 1'b1; req0_op = 3'b000; req0_a = 32'd1; req0_b = 32'd2;
        req1_valid = 1'b1; req1_op = 3'b000; req1_a = 32'd3; req1_b = 32'd4;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;

        // Reset with both requests pending
        @(negedge clk);
        @(negedge clk);
        chk("rst req0_ready", 32'(req0_ready), 32'd0);
        chk("rst req1_ready", 32'(req1_ready), 32'd0);
        chk("rst rsp_valid", 32'({rsp1_valid, rsp0_valid}), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst alu_a", alu_a, 32'd0);
        chk("rst alu_b", alu_b, 32'd0);
        chk("rst alu_ctrl", 32'(alu_ctrl), 32'd0);
        chk("rst result", rsp_result, 32'd0);
        chk("rst grant", 32'(grant_id), 32'd0);

        req0_valid = 1'b0; req1_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);

        // Single add from client 0; operand drive checked in EXEC
        req0_valid = 1'b1; req0_op = 3'b000; req0_a = 32'd5; req0_b = 32'd7;
        #1;
        chk("add req0_ready", 32'(req0_ready), 32'd1);
        @(negedge clk);
        req0_valid = 1'b0; req0_a = 32'hDEAD; req0_b = 32'hBEEF;
        chk("add alu_a", alu_a, 32'd5);
        chk("add alu_b", alu_b, 32'd7);
        chk("add alu_ctrl", 32'(alu_ctrl), 32'd0);
        chk("add exec rsp0_valid", 32'(rsp0_valid), 32'd0);
        @(negedge clk);
        chk("add rsp0_valid", 32'(rsp0_valid), 32'd1);
        chk("add result", rsp_result, 32'd12);
        chk("add flags", 32'({rsp_zero, rsp_sign}), 32'd0);
        @(negedge clk);
        chk("add done busy", 32'(busy), 32'd0);

        // Fresh reset so contention starts from prio 0
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Continuous contention: grants alternate 0,1,0,1,0
        req0_valid = 1'b1; req0_op = 3'b010; req0_a = 32'd3; req0_b = 32'd3;
        req1_valid = 1'b1; req1_op = 3'b101; req1_a = 32'h8000_0000; req1_b = 32'd4;
        serve("rr0", 1'b0, 32'd0, 1'b1, 1'b0);
        serve("rr1", 1'b1, 32'hF800_0000, 1'b0, 1'b1);
        serve("rr2", 1'b0, 32'd0, 1'b1, 1'b0);
        serve("rr3", 1'b1, 32'hF800_0000, 1'b0, 1'b1);
        serve("rr4", 1'b0, 32'd0, 1'b1, 1'b0);

        // prio now 1: client 1 wins, then response is backpressured for 5 cycles
        req1_op = 3'b000; req1_a = 32'd100; req1_b = 32'd23;
        rsp1_ready = 1'b0;
        #1;
        chk("bp req1_ready", 32'(req1_ready), 32'd1);
        chk("bp req0_ready", 32'(req0_ready), 32'd0);
        @(negedge clk);
        req1_valid = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            chk("bp rsp1_valid", 32'(rsp1_valid), 32'd1);
            chk("bp result", rsp_result, 32'd123);
            chk("bp busy", 32'(busy), 32'd1);
            chk("bp req0_ready", 32'(req0_ready), 32'd0);
            @(negedge clk);
        end
        rsp1_ready = 1'b1;
        #1;
        chk("bp last rsp1_valid", 32'(rsp1_valid), 32'd1);
        @(negedge clk);
        chk("bp done rsp1_valid", 32'(rsp1_valid), 32'd0);
        chk("bp done busy", 32'(busy), 32'd0);
        #1;
        chk("bp prio to 0", 32'(req0_ready), 32'd1);

        // Shift and logic ops from client 0 alone
        req0_op = 3'b001; req0_a = 32'd1; req0_b = 32'd4;
        serve("shl", 1'b0, 32'd16, 1'b0, 1'b0);
        req0_op = 3'b100; req0_a = 32'hF0; req0_b = 32'hFF;
        serve("xor", 1'b0, 32'h0F, 1'b0, 1'b0);
        req0_op = 3'b110; req0_a = 32'hF0; req0_b = 32'h0F;
        serve("or", 1'b0, 32'hFF, 1'b0, 1'b0);
        req0_op = 3'b111; req0_a = 32'hF0; req0_b = 32'h3C;
        serve("and", 1'b0, 32'h30, 1'b0, 1'b0);

        // prio is now 1; reset during EXEC must abort and clear it
        #1;
        chk("mr accept", 32'(req0_ready), 32'd1);
        @(negedge clk);
        req0_valid = 1'b0;
        chk("mr in exec", 32'(busy), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("mr busy", 32'(busy), 32'd0);
        for (int i = 0; i < 3; i++) begin
            chk("mr no rsp", 32'({rsp1_valid, rsp0_valid}), 32'd0);
            @(negedge clk);
        end
        req0_valid = 1'b1; req0_op = 3'b000; req0_a = 32'd2; req0_b = 32'd2;
        req1_valid = 1'b1; req1_op = 3'b000; req1_a = 32'd8; req1_b = 32'd8;
        serve("mr grant0", 1'b0, 32'd4, 1'b0, 1'b0);
        req0_valid = 1'b0;

        // Undefined op from client 1
        req1_op = 3'b011; req1_a = 32'd9; req1_b = 32'd9;
        serve("undef", 1'b1, 32'd0, 1'b1, 1'b0);
        req1_valid = 1'b0;
        #1;
        chk("undef idle readies", 32'({req1_ready, req0_ready}), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
